// File: rtl/free_list.sv
// Free physical-register FIFO for rename: refilled by commit, reclaimed on flush.
// Optional macro FREE_LIST_BYPASS_EN forwards a same-cycle enqueue to an empty-FIFO dequeue.
module free_list #(
  parameter int unsigned PHYS_REG_BITS = 6,
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enqueue,
  input  logic [PHYS_REG_BITS-1:0] i_enqueue_pd,
  input  logic                     i_dequeue,
  output logic [PHYS_REG_BITS-1:0] o_dequeue_pd,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_free_count,
  input  logic                     i_flush
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PHYS_REG_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;

  logic [PTR_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_enq_ok;
  logic             w_deq_ok;
  logic             w_bypass;
  logic             w_wr;
  logic [PTR_W-1:0] w_tail_next;
  logic [PTR_W-1:0] w_head_next;

  assign w_count = r_tail - r_head;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == PTR_W'(DEPTH));

  assign w_enq_ok = i_enqueue && (i_enqueue_pd != '0) && !w_full;
  assign w_deq_ok = i_dequeue && !w_empty && !i_flush;

`ifdef FREE_LIST_BYPASS_EN
  // The freed register goes straight to rename; neither pointer moves.
  assign w_bypass = w_empty && i_enqueue && (i_enqueue_pd != '0) && i_dequeue && !i_flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_wr        = w_enq_ok && !w_bypass;
  assign w_tail_next = r_tail + PTR_W'(w_wr);

  // Flush places head one full lap behind tail, reclaiming all speculative allocations.
  always_comb begin
    w_head_next = r_head + PTR_W'(w_deq_ok);
    if (i_flush) begin
      w_head_next = {~w_tail_next[IDX_W], w_tail_next[IDX_W-1:0]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= PHYS_REG_BITS'(NUM_ARCH_REGS + i);
      end
      r_head <= '0;
      r_tail <= PTR_W'(DEPTH);
    end else begin
      if (w_wr) begin
        r_mem[r_tail[IDX_W-1:0]] <= i_enqueue_pd;
      end
      r_head <= w_head_next;
      r_tail <= w_tail_next;
    end
  end

  assign o_dequeue_pd = w_bypass ? i_enqueue_pd : r_mem[r_head[IDX_W-1:0]];
  assign o_empty      = w_empty;
  assign o_full       = w_full;
  assign o_free_count = w_count;

  a_no_enq_when_full: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(i_enqueue && (i_enqueue_pd != '0) && w_full)
  );

endmodule

// File: tb/tb_free_list.sv
// Table-driven bench for free_list: each row drives one cycle and checks pre-edge outputs.
module tb_free_list;

  logic       clk;
  logic       rst_n;
  logic       enqueue;
  logic [5:0] enqueue_pd;
  logic       dequeue;
  logic [5:0] dequeue_pd;
  logic       empty;
  logic       full;
  logic [5:0] free_count;
  logic       flush;

  free_list dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enqueue    (enqueue),
    .i_enqueue_pd (enqueue_pd),
    .i_dequeue    (dequeue),
    .o_dequeue_pd (dequeue_pd),
    .o_empty      (empty),
    .o_full       (full),
    .o_free_count (free_count),
    .i_flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit enq;
    int pd;
    bit deq;
    bit fl;
    bit chk_pd;
    int exp_pd;
    bit exp_empty;
    bit exp_full;
    int exp_count;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_pass;

  task automatic add(input bit rst, input bit enq, input int pd, input bit deq, input bit fl,
                     input bit chk_pd, input int exp_pd, input bit exp_empty,
                     input bit exp_full, input int exp_count);
    vec_t v;
    v.rst = rst; v.enq = enq; v.pd = pd; v.deq = deq; v.fl = fl;
    v.chk_pd = chk_pd; v.exp_pd = exp_pd; v.exp_empty = exp_empty;
    v.exp_full = exp_full; v.exp_count = exp_count;
    vecs.push_back(v);
  endtask

  task automatic check(input int row, input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL row %0d %s: got %0d expected %0d", row, name, got, exp);
  endtask

  initial begin
    rst_n = 1'b0; enqueue = 1'b0; enqueue_pd = '0; dequeue = 1'b0; flush = 1'b0;
    n_checks = 0; n_pass = 0;

    //  rst enq pd  deq fl  chk pd  emp full cnt
    add(1, 0, 0,  0, 0,  1, 32, 0, 1, 32);
    add(0, 0, 0,  0, 0,  1, 32, 0, 1, 32);
    for (int i = 0; i < 32; i++) add(0, 0, 0, 1, 0, 1, 32 + i, 0, (i == 0), 32 - i);
    add(0, 0, 0,  0, 0,  0, 0,  1, 0, 0);
    add(0, 0, 0,  1, 0,  0, 0,  1, 0, 0);   // dequeue while empty
    add(0, 1, 0,  0, 0,  0, 0,  1, 0, 0);   // pd 0 is never freed
    add(0, 0, 0,  0, 0,  0, 0,  1, 0, 0);
    add(0, 1, 40, 0, 0,  0, 0,  1, 0, 0);
    add(0, 1, 5,  0, 0,  1, 40, 0, 0, 1);
    add(0, 0, 0,  0, 0,  1, 40, 0, 0, 2);
    add(0, 0, 0,  1, 0,  1, 40, 0, 0, 2);
    add(0, 0, 0,  1, 0,  1, 5,  0, 0, 1);
    add(0, 0, 0,  0, 0,  0, 0,  1, 0, 0);
`ifdef FREE_LIST_BYPASS_EN
    add(0, 1, 9,  1, 0,  1, 9,  1, 0, 0);
    add(0, 0, 0,  0, 0,  0, 0,  1, 0, 0);
`else
    add(0, 1, 9,  1, 0,  0, 0,  1, 0, 0);
    add(0, 0, 0,  0, 0,  1, 9,  0, 0, 1);
    add(0, 0, 0,  1, 0,  1, 9,  0, 0, 1);
    add(0, 0, 0,  0, 0,  0, 0,  1, 0, 0);
`endif
    for (int k = 0; k < 10; k++) add(0, 1, 20 + k, 0, 0, (k != 0), 20, (k == 0), 0, k);
    add(0, 0, 0,  0, 0,  1, 20, 0, 0, 10);
    add(0, 1, 7,  1, 0,  1, 20, 0, 0, 10);  // simultaneous enqueue + dequeue
    add(0, 0, 0,  0, 0,  1, 21, 0, 0, 10);
    for (int j = 0; j < 10; j++) add(0, 0, 0, 1, 0, 1, (j < 9) ? 21 + j : 7, 0, 0, 10 - j);
    add(0, 0, 0,  0, 0,  0, 0,  1, 0, 0);
    add(0, 1, 50, 0, 0,  0, 0,  1, 0, 0);
    add(1, 0, 0,  1, 0,  1, 32, 0, 1, 32);  // reset mid-operation
    add(0, 0, 0,  0, 0,  1, 32, 0, 1, 32);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 1, 32 + i, 0, (i == 0), 32 - i);
    add(0, 1, 12, 1, 1,  1, 37, 0, 0, 27);  // flush with committing enqueue
    add(0, 0, 0,  0, 0,  1, 33, 0, 1, 32);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 1, 33 + i, 0, (i == 0), 32 - i);
    add(0, 0, 0,  0, 1,  1, 38, 0, 0, 27);  // flush alone
    add(0, 0, 0,  0, 0,  1, 33, 0, 1, 32);

    foreach (vecs[r]) begin
      @(negedge clk);
      rst_n      = !vecs[r].rst;
      enqueue    = vecs[r].enq;
      enqueue_pd = 6'(vecs[r].pd);
      dequeue    = vecs[r].deq;
      flush      = vecs[r].fl;
      #1;
      if (vecs[r].chk_pd) check(r, "dequeue_pd", int'(dequeue_pd), vecs[r].exp_pd);
      check(r, "empty", int'(empty), int'(vecs[r].exp_empty));
      check(r, "full", int'(full), int'(vecs[r].exp_full));
      check(r, "free_count", int'(free_count), vecs[r].exp_count);
    end

    @(negedge clk);
    enqueue = 1'b0; dequeue = 1'b0; flush = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
